// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL bit layout, mode codes and FSM state encoding.
package timer_pkg;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

endpackage

// File: rtl/timer_regs.sv
// Bus-facing register file of the timer: window decode, CTRL/PRESET writes
// and the combinational read mux. COUNT lives in the FSM and is only read here.
module timer_regs
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PrAddr,
   input  logic [31:0] PrWD,
   input  logic        PrWe,
   output logic [31:0] PrRD,
   input  logic [31:0] count,
   input  logic        hw_clr_en,
   output logic        en,
   output logic [1:0]  mode,
   output logic        im,
   output logic [31:0] preset,
   output logic        ctrl_wr
);

   logic       sel;
   logic       wr;
   logic [1:0] off;
   logic [3:0] ctrl;
   logic       unused_addr;

   assign sel         = (PrAddr[31:4] == BASE[31:4]);
   assign off         = PrAddr[3:2];
   assign wr          = sel & PrWe;
   assign ctrl_wr     = wr && (off == OFF_CTRL);
   assign unused_addr = ^PrAddr[1:0];

   assign en   = ctrl[CTRL_EN];
   assign mode = ctrl[CTRL_MODE +: 2];
   assign im   = ctrl[CTRL_IM];

   // A bus CTRL write overrides the FSM's one-shot EN clear in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl   <= '0;
         preset <= '0;
      end else begin
         if (ctrl_wr)
            ctrl <= PrWD[3:0];
         else if (hw_clr_en)
            ctrl[CTRL_EN] <= 1'b0;
         if (wr && (off == OFF_PRESET))
            preset <= PrWD;
      end
   end

   always_comb begin
      PrRD = '0;
      if (sel) begin
         case (off)
            OFF_CTRL:   PrRD = {28'd0, ctrl};
            OFF_PRESET: PrRD = preset;
            OFF_COUNT:  PrRD = count;
            default:    PrRD = '0;
         endcase
      end
   end

endmodule

// File: rtl/timer_dev.sv
// Countdown timer responder on the CPU processor bus; IRQ feeds one HWInt bit.
// Register file in timer_regs, load/count/expire FSM and counter here.
module timer_dev
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PrAddr,
   input  logic [31:0] PrWD,
   input  logic        PrWe,
   output logic [31:0] PrRD,
   output logic        IRQ
);

   state_t      state, state_nx;
   logic [31:0] count;
   logic [31:0] preset;
   logic        irq_flag;
   logic        en, im, ctrl_wr;
   logic [1:0]  mode;
   logic        reload;
   logic        load_cnt, dec_cnt, set_flag, clr_flag, clr_en;

   timer_regs #(.BASE(BASE)) u_regs (
      .clk       (clk),
      .reset     (reset),
      .PrAddr    (PrAddr),
      .PrWD      (PrWD),
      .PrWe      (PrWe),
      .PrRD      (PrRD),
      .count     (count),
      .hw_clr_en (clr_en),
      .en        (en),
      .mode      (mode),
      .im        (im),
      .preset    (preset),
      .ctrl_wr   (ctrl_wr)
   );

   // Modes 2 and 3 fall back to one-shot.
   assign reload = (mode == MODE_RELOAD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (en) state_nx = LOAD;
         LOAD:    state_nx = CNT;
         CNT: begin
            if (!en)              state_nx = IDLE;
            else if (count == '0) state_nx = INT;
         end
         INT:     state_nx = reload ? LOAD : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load_cnt = (state == LOAD);
      dec_cnt  = (state == CNT) && en && (count != '0);
      set_flag = (state == CNT) && en && (count == '0);
      clr_flag = (state == INT) && reload;
      clr_en   = (state == INT) && !reload;
   end

   // CTRL writes clear the flag even when expiry lands in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         if (load_cnt)     count <= preset;
         else if (dec_cnt) count <= count - 32'd1;
         if (ctrl_wr)       irq_flag <= 1'b0;
         else if (set_flag) irq_flag <= 1'b1;
         else if (clr_flag) irq_flag <= 1'b0;
      end
   end

   assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed vector table, multi-cycle corner
// sequences and a randomized run against a cycle-level behavioural model.
module tb_timer_dev;

   localparam logic [31:0] B = 32'h0000_7F00;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] PrAddr = '0;
   logic [31:0] PrWD = '0;
   logic        PrWe = 1'b0;
   logic [31:0] PrRD;
   logic        IRQ;

   timer_dev #(.BASE(B)) dut (
      .clk    (clk),
      .reset  (reset),
      .PrAddr (PrAddr),
      .PrWD   (PrWD),
      .PrWe   (PrWe),
      .PrRD   (PrRD),
      .IRQ    (IRQ)
   );

   always #10 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Behavioural model: phase 0 waiting for EN, 1 reload, 2 counting, 3 expired.
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset, m_count;
   logic        m_flag;
   int          m_ph;

   task automatic model_reset();
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_ph = 0;
   endtask

   task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic we);
      logic [3:0]  c;
      logic [31:0] p, n;
      logic        f;
      int          ph;
      c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_ph;
      if (m_ph == 0) begin
         if (m_ctrl[0]) ph = 1;
      end else if (m_ph == 1) begin
         n = m_preset; ph = 2;
      end else if (m_ph == 2) begin
         if (!m_ctrl[0]) ph = 0;
         else if (m_count == 0) begin f = 1'b1; ph = 3; end
         else n = m_count - 1;
      end else begin
         if (m_ctrl[2:1] == 2'd1) begin f = 1'b0; ph = 1; end
         else begin c[0] = 1'b0; ph = 0; end
      end
      if (we && a[31:4] == B[31:4]) begin
         if (a[3:2] == 2'd0) begin c = d[3:0]; f = 1'b0; end
         if (a[3:2] == 2'd1) p = d;
      end
      m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_ph = ph;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:4] != B[31:4]) return '0;
      case (a[3:2])
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   task automatic tick();
      if (reset) model_edge(PrAddr, PrWD, PrWe);
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      PrAddr = a; PrWe = 1'b0;
      #1;
      d = PrRD;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      PrAddr = a; PrWD = d; PrWe = 1'b1;
      tick();
      PrWe = 1'b0;
   endtask

   task automatic poll_count(input logic [31:0] v, input int lim, input string nm);
      logic [31:0] d;
      logic        ok;
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         rd(B + 8, d);
         if (d == v) ok = 1'b1;
         else tick();
      end
      chk(nm, {31'd0, ok}, 32'd1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
      logic        we;
      logic [31:0] rd;
      logic        irq;
   } vec_t;

   vec_t vecs[19];

   initial begin
      logic [31:0] d;
      int          rises[$];
      int          wr_at, wide, r, off;
      logic        prev, seen;
      logic [31:0] a;

      // One-shot walk: PRESET=5, CTRL=0x9 written at edge 0, IRQ at edge 8.
      vecs[0]  = '{B + 0,  32'd0, 1'b0, 32'd0, 1'b0};
      vecs[1]  = '{B + 4,  32'd0, 1'b0, 32'd0, 1'b0};
      vecs[2]  = '{B + 8,  32'd0, 1'b0, 32'd0, 1'b0};
      vecs[3]  = '{B + 16, 32'd0, 1'b0, 32'd0, 1'b0};
      vecs[4]  = '{B + 4,  32'd5, 1'b1, 32'd0, 1'b0};
      vecs[5]  = '{B + 0,  32'h9, 1'b1, 32'd0, 1'b0};
      vecs[6]  = '{B + 8,  32'd0, 1'b0, 32'd0, 1'b0};
      vecs[7]  = '{B + 8,  32'd0, 1'b0, 32'd0, 1'b0};
      vecs[8]  = '{B + 8,  32'd0, 1'b0, 32'd5, 1'b0};
      vecs[9]  = '{B + 8,  32'd0, 1'b0, 32'd4, 1'b0};
      vecs[10] = '{B + 8,  32'd0, 1'b0, 32'd3, 1'b0};
      vecs[11] = '{B + 8,  32'd0, 1'b0, 32'd2, 1'b0};
      vecs[12] = '{B + 8,  32'd0, 1'b0, 32'd1, 1'b0};
      vecs[13] = '{B + 8,  32'd0, 1'b0, 32'd0, 1'b0};
      vecs[14] = '{B + 8,  32'd0, 1'b0, 32'd0, 1'b1};
      vecs[15] = '{B + 0,  32'd0, 1'b0, 32'h8, 1'b1};
      vecs[16] = '{B + 0,  32'd0, 1'b0, 32'h8, 1'b1};
      vecs[17] = '{B + 0,  32'h0, 1'b1, 32'h8, 1'b1};
      vecs[18] = '{B + 0,  32'd0, 1'b0, 32'd0, 1'b0};

      model_reset();
      #1;
      chk("reset_irq", {31'd0, IRQ}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 19; i++) begin
         PrAddr = vecs[i].addr; PrWD = vecs[i].wd; PrWe = vecs[i].we;
         #1;
         chk($sformatf("vec%0d_rd", i), PrRD, vecs[i].rd);
         chk($sformatf("vec%0d_irq", i), {31'd0, IRQ}, {31'd0, vecs[i].irq});
         tick();
         PrWe = 1'b0;
      end

      // Auto-reload: period 6 with PRESET=3, then 10 once PRESET=7 reloads.
      wr(B + 4, 32'd3);
      wr(B + 0, 32'hB);
      wr_at = -1; prev = 1'b0; wide = 0;
      for (int c = 0; c < 45; c++) begin
         if (c == wr_at) wr(B + 4, 32'd7);
         else tick();
         if (IRQ && prev) wide++;
         if (IRQ && !prev) begin
            rises.push_back(c);
            if (rises.size() == 2) wr_at = c + 3;
         end
         prev = IRQ;
      end
      chk("m1_rises", rises.size(), (rises.size() >= 4) ? rises.size() : 4);
      chk("m1_period1", (rises.size() >= 2) ? rises[1] - rises[0] : -1, 6);
      chk("m1_period2", (rises.size() >= 3) ? rises[2] - rises[1] : -1, 6);
      chk("m1_period3", (rises.size() >= 4) ? rises[3] - rises[2] : -1, 10);
      chk("m1_pulse_width", wide, 0);
      rd(B + 0, d);
      chk("m1_ctrl", d, 32'hB);
      wr(B + 0, 32'h0);
      repeat (3) tick();

      // Masked expiry: flag set but IRQ never visible, then cleared by CTRL write.
      wr(B + 4, 32'd2);
      wr(B + 0, 32'h1);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (IRQ) seen = 1'b1;
      end
      chk("mask_irq", {31'd0, seen}, 32'd0);
      rd(B + 8, d);
      chk("mask_count", d, 32'd0);
      rd(B + 0, d);
      chk("mask_ctrl", d, 32'h0);
      wr(B + 0, 32'h8);
      tick();
      chk("mask_im_irq", {31'd0, IRQ}, 32'd0);

      // EN cleared on the edge that brings COUNT to 4: counter parks at 4.
      wr(B + 4, 32'd10);
      wr(B + 0, 32'h1);
      poll_count(32'd5, 30, "frz_reach5");
      wr(B + 0, 32'h0);
      repeat (4) tick();
      rd(B + 8, d);
      chk("frz_count", d, 32'd4);
      wr(B + 8, 32'h1234);
      rd(B + 8, d);
      chk("frz_count_wr", d, 32'd4);
      wr(B + 12, 32'hFFFF_FFFF);
      rd(B + 12, d);
      chk("rsvd_rd", d, 32'd0);
      rd(B + 4, d);
      chk("frz_preset", d, 32'd10);

      // Async reset mid-count aborts with everything cleared and no IRQ.
      wr(B + 4, 32'd5);
      wr(B + 0, 32'h9);
      poll_count(32'd2, 20, "rst_reach2");
      reset = 1'b0;
      model_reset();
      rd(B + 8, d);
      chk("rst_count", d, 32'd0);
      rd(B + 0, d);
      chk("rst_ctrl", d, 32'd0);
      rd(B + 4, d);
      chk("rst_preset", d, 32'd0);
      chk("rst_irq_now", {31'd0, IRQ}, 32'd0);
      tick(); tick();
      reset = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (IRQ) seen = 1'b1;
      end
      chk("rst_no_irq", {31'd0, seen}, 32'd0);

      // CTRL write lands on the INT edge: written EN survives the one-shot clear.
      wr(B + 4, 32'd1);
      wr(B + 0, 32'h9);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (IRQ) seen = 1'b1;
         else tick();
      end
      chk("race_reach_int", {31'd0, seen}, 32'd1);
      wr(B + 0, 32'h9);
      rd(B + 0, d);
      chk("race_ctrl", d, 32'h9);
      chk("race_irq_clr", {31'd0, IRQ}, 32'd0);
      repeat (3) tick();
      chk("race_irq_early", {31'd0, IRQ}, 32'd0);
      tick();
      chk("race_irq_again", {31'd0, IRQ}, 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 199);
         if (r == 0) begin
            reset = 1'b0;
            model_reset();
            #1;
            chk("rand_rst_irq", {31'd0, IRQ}, 32'd0);
            tick();
            reset = 1'b1;
         end else begin
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = B + 32'(off * 4) + 32'($urandom_range(0, 3));
            PrAddr = a;
            PrWe = ($urandom_range(0, 3) == 0);
            PrWD = (off == 1) ? 32'($urandom_range(0, 8)) : $urandom;
            #1;
            chk("rand_rd", PrRD, model_read(a));
            chk("rand_irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
            tick();
            PrWe = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that acts as a responder on the processor bus (PrAddr/PrWD/PrWe/PrRD) driven by the pipelined MIPS CPU. It decodes its own 16-byte window, exposes CTRL/PRESET/COUNT registers, and raises an interrupt line wired to one bit of the CPU's `HWInt[15:10]` input. Two instances sit behind the system bridge: Timer0 on `HWInt[10]` and Timer1 on `HWInt[11]`.

## Interface
- `BASE`, default 32'h0000_7F00: window base address; must be 16-byte aligned.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `PrAddr`  input  32  bus address from the CPU memory stage.
- `PrWD`  input  32  bus write data.
- `PrWe`  input  1  bus write enable, one cycle per store.
- `PrRD`  output  32  combinational read data; 0 when not selected.
- `IRQ`  output  1  level interrupt request to the CPU `HWInt` bit.

## Operation
- Select: `sel = (PrAddr[31:4] == BASE[31:4])`. Offset `PrAddr[3:2]`: 0 = CTRL, 1 = PRESET, 2 = COUNT (read-only), 3 = reserved (reads 0, writes ignored).
- CTRL bits:
  - [0] EN.
  - [2:1] MODE: 0 = one-shot, 1 = auto-reload; 2 and 3 behave as 0.
  - [3] IM (interrupt mask, 1 = enabled).
  - [31:4] read 0.
- Writes occur only when `sel & PrWe`. Writes to COUNT and to offset 3 are ignored.
- Any CTRL write clears `irq_flag`. `IRQ = IM & irq_flag`.
- FSM states:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT frozen. Else if COUNT == 0, go to INT and set `irq_flag`. Else COUNT <= COUNT-1.
  - INT, MODE 0: EN <= 0, go to IDLE; `irq_flag` holds.
  - INT, MODE 1: `irq_flag` <= 0, go to LOAD.
- Simultaneous events:
  - A bus CTRL write in the same cycle as the INT hardware clear of EN wins.
  - A PRESET write during counting affects only the next LOAD. A PRESET write in the LOAD cycle loads the old value.
- Arithmetic: 32-bit unsigned. COUNT never wraps below 0. PRESET = 0 reaches INT on the cycle after LOAD.

## Timing
- Reset (async, `reset` low): CTRL = 0, PRESET = 0, COUNT = 0, `irq_flag` = 0, state IDLE, IRQ = 0. Reset asserted mid-count aborts immediately, with no IRQ.
- Reads: combinational, same cycle as the address. A register written at edge t reads its new value after t.
- Latency: CTRL write with EN = 1 at edge 0 gives LOAD at edge 1, COUNT = N at edge 2, COUNT = 0 at edge 2+N, and `irq_flag` = 1 at edge 3+N.
- MODE 1 period: N+3 cycles between IRQ rises. IRQ is high for exactly one cycle when IM = 1.
- MODE 0: IRQ stays high until the next CTRL write or a reset.

## Structure
- Shared package `timer_pkg`:
  - register offsets (CTRL = 2'd0, PRESET = 2'd1, COUNT = 2'd2);
  - CTRL bit positions;
  - MODE codes;
  - state enum {IDLE, LOAD, CNT, INT}.
- Sub-module `timer_regs`: address decode, register writes and read mux. The FSM and counter stay in `timer_dev`.
- The system bridge instantiates `timer_dev` twice with distinct `BASE`.

## Test plan
- Reset release, then read BASE+0/+4/+8 -> all 0. Read an unselected address -> PrRD = 0, IRQ = 0.
- PRESET = 5, CTRL = 0x9 (EN, MODE 0, IM) -> COUNT reads 5,4,3,2,1,0. IRQ rises 8 cycles after the CTRL write edge and stays high. CTRL reads 0x8. A CTRL write of 0 drops IRQ next cycle.
- PRESET = 3, CTRL = 0xB (MODE 1) -> IRQ one-cycle pulses every 6 cycles. EN stays 1. A PRESET write of 7 mid-count takes effect from the next reload (period 10).
- CTRL = 0x1 (IM = 0), PRESET = 2 -> counter expires and IRQ stays 0. A following write of CTRL = 0x8 leaves IRQ at 0 because the flag was cleared.
- Clear EN mid-count at COUNT = 4 -> COUNT frozen at its value. Write to COUNT (0x1234) -> ignored.
- Assert `reset` low with COUNT = 2 in MODE 0 -> all registers 0 immediately, no IRQ pulse. Simultaneous CTRL write with INT clear -> written EN value kept.
